// File: rtl/jump_pkg.sv
// Shared definitions for the jump-command datapath: widths, command codes and
// sequencer state encoding.
package jump_pkg;

    localparam int ADDR_W_DEF    = 11;
    localparam int STK_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        CMD_NEXT = 3'd0,
        CMD_JMP  = 3'd1,
        CMD_JZ   = 3'd2,
        CMD_CALL = 3'd3,
        CMD_RET  = 3'd4,
        CMD_HALT = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

endpackage

// File: rtl/jump_ctrl.sv
// Program-counter sequencer: next-PC mux, run/halt/fault FSM and return-stack
// depth tracking. The return-address stack itself is a sibling instance.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, pc held until start
// ST_RUN   | executing one command per unstalled cycle
// ST_HALT  | HALT retired, pc points past it, start resumes
// ST_FAULT | stack overflow/underflow trapped, sticky until reset
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int STK_DEPTH = STK_DEPTH_DEF,
    parameter int RESET_PC  = 0,
    localparam int DEPTH_W  = $clog2(STK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic [2:0]         cmd,
    input  logic [ADDR_W-1:0]  target,
    input  logic               zero,
    input  logic [ADDR_W-1:0]  stack_out,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  stack_in,
    output logic               push,
    output logic               pop,
    output logic [DEPTH_W-1:0] depth,
    output logic               halted,
    output logic               fault
);

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STK_DEPTH);
    localparam logic [ADDR_W-1:0]  PC_INIT    = ADDR_W'(RESET_PC);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [ADDR_W-1:0]   pc_inc;
    logic                run_active;
    logic                stk_full;
    logic                stk_empty;

    assign pc_inc     = pc_q + 1'b1;
    assign run_active = (state_q == ST_RUN) && !stall;
    assign stk_full   = (depth_q == DEPTH_FULL);
    assign stk_empty  = (depth_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_INIT;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    case (cmd)
                        CMD_JMP: pc_d = target;
                        CMD_JZ:  pc_d = zero ? target : pc_inc;
                        CMD_CALL: begin
                            if (stk_full) begin
                                state_d = ST_FAULT;
                            end else begin
                                pc_d    = target;
                                depth_d = depth_q + 1'b1;
                            end
                        end
                        CMD_RET: begin
                            if (stk_empty) begin
                                state_d = ST_FAULT;
                            end else begin
                                pc_d    = stack_out;
                                depth_d = depth_q - 1'b1;
                            end
                        end
                        CMD_HALT: begin
                            pc_d    = pc_inc;
                            state_d = ST_HALT;
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            ST_HALT: begin
                if (start) state_d = ST_RUN;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are gated by reset so an in-flight CALL/RET never reaches the stack.
    always_comb begin
        push   = 1'b0;
        pop    = 1'b0;
        halted = (state_q == ST_HALT);
        fault  = (state_q == ST_FAULT);
        if (run_active && !reset) begin
            push = (cmd == CMD_CALL) && !stk_full;
            pop  = (cmd == CMD_RET)  && !stk_empty;
        end
    end

    assign pc       = pc_q;
    assign depth    = depth_q;
    assign stack_in = pc_inc;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl with a behavioural return-address stack as the
// sibling that consumes push/pop and feeds stack_out.
module tb_jump_ctrl;
    import jump_pkg::*;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stall;
    logic [2:0]    cmd;
    logic [AW-1:0] target;
    logic          zero;
    logic [AW-1:0] stack_out;
    logic [AW-1:0] pc;
    logic [AW-1:0] stack_in;
    logic          push;
    logic          pop;
    logic [4:0]    depth;
    logic          halted;
    logic          fault;

    int tests = 0;
    int fails = 0;

    jump_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .cmd       (cmd),
        .target    (target),
        .zero      (zero),
        .stack_out (stack_out),
        .pc        (pc),
        .stack_in  (stack_in),
        .push      (push),
        .pop       (pop),
        .depth     (depth),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Sibling stack: combinational top-of-stack read, pointer moves on the edge.
    logic [AW-1:0] mem [16];
    int            sp;

    always_comb begin
        stack_out = '0;
        if (sp > 0) stack_out = mem[sp-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= 0;
        end else if (push && sp < 16) begin
            mem[sp] <= stack_in;
            sp      <= sp + 1;
        end else if (pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [AW-1:0] t);
        cmd    = c;
        target = t;
        cyc();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        cmd = CMD_NEXT; target = '0; zero = 1'b0;
        cyc(); cyc();
        check("rst_pc", pc, 0);
        check("rst_depth", depth, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_push", push, 0);
        check("rst_pop", pop, 0);

        reset = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("idle_pc_held", pc, 0);

        // Sequential execution
        for (int i = 1; i <= 3; i++) begin
            cmd = CMD_NEXT;
            #1;
            check("next_push", push, 0);
            check("next_pop", pop, 0);
            cyc();
            check("next_pc", pc, i);
        end
        check("next_depth", depth, 0);

        do_cmd(CMD_NEXT, 0);
        do_cmd(CMD_NEXT, 0);
        check("pc_at_5", pc, 5);

        // CALL / NEXT / RET round trip
        cmd = CMD_CALL; target = 11'h100;
        #1;
        check("call_push", push, 1);
        check("call_stack_in", stack_in, 6);
        check("call_pop", pop, 0);
        cyc();
        check("call_pc", pc, 11'h100);
        check("call_depth", depth, 1);
        check("stack_top_after_call", stack_out, 6);
        do_cmd(CMD_NEXT, 0);
        check("sub_pc", pc, 11'h101);
        check("sub_depth", depth, 1);
        cmd = CMD_RET;
        #1;
        check("ret_pop", pop, 1);
        check("ret_push", push, 0);
        cyc();
        check("ret_pc", pc, 6);
        check("ret_depth", depth, 0);

        // Nested calls and back-to-back returns
        do_cmd(CMD_JMP, 11'd1);
        check("jmp_pc", pc, 1);
        do_cmd(CMD_CALL, 11'h10);
        do_cmd(CMD_CALL, 11'h20);
        do_cmd(CMD_CALL, 11'h30);
        check("nest_pc", pc, 11'h30);
        check("nest_depth", depth, 3);
        do_cmd(CMD_RET, 0);
        check("nret1_pc", pc, 11'h21);
        do_cmd(CMD_RET, 0);
        check("nret2_pc", pc, 11'h11);
        do_cmd(CMD_RET, 0);
        check("nret3_pc", pc, 2);
        check("nret_depth", depth, 0);

        // Conditional jump
        zero = 1'b0;
        do_cmd(CMD_JZ, 11'h40);
        check("jz_not_taken", pc, 3);
        zero = 1'b1;
        do_cmd(CMD_JZ, 11'h40);
        check("jz_taken", pc, 11'h40);
        zero = 1'b0;

        // Unused encodings advance like NEXT
        do_cmd(3'd6, 11'h7ff);
        check("cmd6_pc", pc, 11'h41);
        do_cmd(3'd7, 11'h7ff);
        check("cmd7_pc", pc, 11'h42);

        // HALT, stall, resume
        do_cmd(CMD_JMP, 11'd9);
        do_cmd(CMD_HALT, 0);
        check("halt_pc", pc, 10);
        check("halt_flag", halted, 1);
        stall = 1'b1;
        cyc();
        check("halt_stall_pc", pc, 10);
        stall = 1'b0;
        do_cmd(CMD_JMP, 11'h55);
        check("halt_ignores_cmd", pc, 10);
        check("halt_still", halted, 1);
        start = 1'b1; stall = 1'b1; cmd = CMD_NEXT;
        cyc();
        start = 1'b0;
        check("resume_halted", halted, 0);
        check("resume_pc", pc, 10);
        cmd = CMD_CALL; target = 11'h300;
        #1;
        check("stall_call_push", push, 0);
        cyc();
        check("stall_call_pc", pc, 10);
        check("stall_call_depth", depth, 0);
        stall = 1'b0;
        do_cmd(CMD_NEXT, 0);
        check("resume_next_pc", pc, 11);

        // PC wrap
        do_cmd(CMD_JMP, 11'h7ff);
        do_cmd(CMD_NEXT, 0);
        check("wrap_pc", pc, 0);

        // Underflow
        cmd = CMD_RET;
        #1;
        check("uflow_pop", pop, 0);
        cyc();
        check("uflow_fault", fault, 1);
        check("uflow_pc", pc, 0);
        start = 1'b1;
        do_cmd(CMD_JMP, 11'h123);
        start = 1'b0;
        check("fault_sticky", fault, 1);
        check("fault_pc_held", pc, 0);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("fault_cleared", fault, 0);

        // Overflow
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            do_cmd(CMD_CALL, 11'(11'h200 + i));
        end
        check("full_depth", depth, 16);
        check("full_pc", pc, 11'h20f);
        cmd = CMD_CALL; target = 11'h3aa;
        #1;
        check("oflow_push", push, 0);
        cyc();
        check("oflow_fault", fault, 1);
        check("oflow_pc", pc, 11'h20f);
        check("oflow_depth", depth, 16);
        cyc();
        check("oflow_sticky", fault, 1);

        // Reset during a pending CALL suppresses the strobe
        reset = 1'b1;
        #1;
        check("rst_gates_push", push, 0);
        cyc();
        reset = 1'b0;
        check("rst2_fault", fault, 0);
        check("rst2_depth", depth, 0);
        check("rst2_pc", pc, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
